pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Decodes load-use hazards, taken-branch redirects, data-memory wait states and halt requests, and drives the write-enable / bubble / flush controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sits beside the datapath in the core top level. EX/MEM and MEM/WB registers in the core are built with the hold and bubble inputs this block drives.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles on one data-memory access before forced completion.
- DRAIN_CYCLES, 4: cycles spent draining in-flight instructions after a halt request.
- TO_W, 8: width of the timeout counter; MEM_TIMEOUT must be below 2^TO_W.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- i_ID_rs, i_ID_rt  input  5 each  source registers of the instruction in ID.
- i_ID_UsesRs, i_ID_UsesRt  input  1 each  ID instruction reads rs / rt.
- i_EX_MemRead  input  1  instruction in EX is a load.
- i_EX_WriteReg  input  5  destination register of the EX instruction.
- i_EX_BranchTaken  input  1  branch or jump resolved taken in EX.
- i_MEM_MemRead, i_MEM_MemWrite  input  1 each  MEM-stage access request, taken from the EX/MEM outputs.
- i_dmem_ready  input  1  data memory completes the current access this cycle.
- i_halt_req  input  1  level request to stop fetching and drain.
- o_PCWrite  output  1  PC register enable.
- o_IF_ID_Write  output  1  IF/ID enable.
- o_IF_ID_Flush  output  1  IF/ID loads a NOP.
- o_ID_EX_Bubble  output  1  ID/EX loads zeroed controls.
- o_EX_MEM_Hold  output  1  EX/MEM keeps its value.
- o_MEM_WB_Bubble  output  1  MEM/WB loads zeroed controls.
- o_dmem_req  output  1  data-memory request strobe.
- o_mem_err  output  1  one-cycle pulse on access timeout.
- o_halted  output  1  pipeline is drained and frozen.
- o_stall_cycles  output  32  stall-cycle count (see Configuration).

## Operation
- Registered state, encoded in the shared package: RUN, MEM_WAIT, DRAIN, HALTED. All control outputs are combinational from the registered state and the current inputs.
- Defaults in RUN with no event: PCWrite=1, IF_ID_Write=1, every flush, bubble and hold output 0.
- Memory access: o_dmem_req = (i_MEM_MemRead | i_MEM_MemWrite) whenever state is RUN, MEM_WAIT or DRAIN.
  - An access with i_dmem_ready=0 is a memory stall: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=0, EX_MEM_Hold=1, MEM_WB_Bubble=1.
  - From RUN, a memory stall moves to MEM_WAIT.
- MEM_WAIT: the memory-stall outputs stay asserted while i_dmem_ready=0, and the timeout counter increments each cycle.
  - On i_dmem_ready=1: release the hold in that cycle (normal enables) and return to RUN, or to DRAIN if i_halt_req=1.
  - When the counter reaches MEM_TIMEOUT: pulse o_mem_err, release the hold as if ready, and exit the same way.
- Event priority: memory stall > taken branch > load-use.
  - Taken branch: IF_ID_Flush=1 and ID_EX_Bubble=1 for one cycle; PC advances to the branch target.
  - Load-use: when i_EX_MemRead is set, i_EX_WriteReg is not 0, and (rs matches with UsesRs, or rt matches with UsesRt): PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle.
  - While frozen in MEM_WAIT, a taken branch stays asserted at the EX input and is acted on in the release cycle.
- Halt: i_halt_req seen in RUN moves to DRAIN.
  - DRAIN: PCWrite=0, IF_ID_Flush=1, the drain counter counts DRAIN_CYCLES.
  - A memory stall during DRAIN pauses the drain count and applies the memory-stall outputs.
  - When the count completes: go to HALTED.
- HALTED: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, MEM_WB_Bubble=1, o_dmem_req=0, o_halted=1. Deasserting i_halt_req returns to RUN on the next cycle.
- Register $0 never creates a hazard.

## Timing
- Reset: state=RUN, both counters 0, o_stall_cycles=0, o_mem_err=0, o_halted=0.
  - During reset every control output is forced to its stalled value: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, MEM_WB_Bubble=1, dmem_req=0.
- Reset asserted in any state, including mid-wait or mid-drain, takes effect at the next clk edge with no completion of the pending access.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed slots (IF and ID).
- A memory wait of N cycles costs N stall cycles. An access ready in its first cycle costs 0.
- The timeout counter clears on every state entry.

## Configuration
- PIPE_PERF_CNT_EN defined: o_stall_cycles increments once for every cycle in which PCWrite=0 while state is not HALTED. It saturates at 0xFFFFFFFF.
- Not defined: o_stall_cycles is tied to 0 and no counter flops are built.

## Structure
- A shared package, pipe_ctrl_pkg, holds the state enum, the state encodings and the default control-bundle constant. The datapath pipeline registers share these.
- One sub-module, hazard_detect: the purely combinational load-use compare.
- The FSM, the counters and the priority mux stay in pipe_hazard_ctrl.

## Test plan
- Load r5 in EX, ID reads rt=5 with UsesRt=1: one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. With i_EX_WriteReg=0 instead: no stall.
- i_EX_BranchTaken=1 for one cycle: IF_ID_Flush=1 and ID_EX_Bubble=1 for exactly one cycle, PCWrite=1.
- MEM load with i_dmem_ready low for 3 cycles: EX_MEM_Hold=1 and MEM_WB_Bubble=1 for 3 cycles, then release. o_stall_cycles=3 when PIPE_PERF_CNT_EN is defined.
- Ready never arrives with MEM_TIMEOUT=4: o_mem_err pulses once at the 4th wait cycle, then the state returns to RUN.
- Memory wait with a taken branch pending in EX: the flush fires in the release cycle, not before.
- i_halt_req with DRAIN_CYCLES=4: o_halted rises 4 cycles later; dropping the request returns to RUN. Reset asserted mid-DRAIN: state=RUN, o_halted=0 after one edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and control bundles.
// Used by pipe_hazard_ctrl, hazard_detect and the datapath pipeline registers.
// Optional feature macro consumed by the top: PIPE_PERF_CNT_EN (stall counter).
package pipe_ctrl_pkg;

  // FSM state encodings (plain constants so legacy datapath code can compare them)
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_DRAIN    = 2'd2;
  localparam state_t ST_HALTED   = 2'd3;

  // Architectural zero register never produces a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bundle driven into the PC and pipeline registers
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } ctrl_t;

  // Free-running pipeline, no events
  localparam ctrl_t CTRL_RUN       = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  // Frozen pipeline (reset / halted)
  localparam ctrl_t CTRL_STALLED   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  // Data memory not ready: hold EX/MEM, feed bubbles into WB
  localparam ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources and the EX load.
// Ports: id_rs_i/id_rt_i + uses flags (ID reader), ex_mem_read_i/ex_write_reg_i (EX load),
//        load_use_o (ID must wait one cycle for the load data).
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_write_reg_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit     = id_uses_rs_i && (id_rs_i == ex_write_reg_i);
  assign rt_hit     = id_uses_rt_i && (id_rt_i == ex_write_reg_i);
  assign load_use_o = ex_mem_read_i && (ex_write_reg_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline (FSM RUN/MEM_WAIT/DRAIN/HALTED).
// Ports: hazard sources from ID/EX/MEM, dmem handshake, halt request; drives PC/IF-ID/ID-EX/
//        EX-MEM/MEM-WB enables, dmem_req, mem_err pulse, halted flag, stall counter (PIPE_PERF_CNT_EN).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4,
  parameter int TO_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ID_rs,
  input  logic [4:0]  i_ID_rt,
  input  logic        i_ID_UsesRs,
  input  logic        i_ID_UsesRt,
  input  logic        i_EX_MemRead,
  input  logic [4:0]  i_EX_WriteReg,
  input  logic        i_EX_BranchTaken,
  input  logic        i_MEM_MemRead,
  input  logic        i_MEM_MemWrite,
  input  logic        i_dmem_ready,
  input  logic        i_halt_req,
  output logic        o_PCWrite,
  output logic        o_IF_ID_Write,
  output logic        o_IF_ID_Flush,
  output logic        o_ID_EX_Bubble,
  output logic        o_EX_MEM_Hold,
  output logic        o_MEM_WB_Bubble,
  output logic        o_dmem_req,
  output logic        o_mem_err,
  output logic        o_halted,
  output logic [31:0] o_stall_cycles
);

  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [DR_W-1:0] dr_cnt_q, dr_cnt_d;

  logic  load_use;
  logic  mem_access;
  logic  timeout;
  logic  mem_stall;
  ctrl_t ctrl_evt;
  ctrl_t ctrl;
  logic  dmem_req;
  logic  mem_err;
  logic  halted;

  hazard_detect u_hazard_detect (
    .id_rs_i        (i_ID_rs),
    .id_rt_i        (i_ID_rt),
    .id_uses_rs_i   (i_ID_UsesRs),
    .id_uses_rt_i   (i_ID_UsesRt),
    .ex_mem_read_i  (i_EX_MemRead),
    .ex_write_reg_i (i_EX_WriteReg),
    .load_use_o     (load_use)
  );

  assign mem_access = i_MEM_MemRead | i_MEM_MemWrite;

  // The timeout fires on the MEM_TIMEOUT-th wait cycle counted by to_cnt
  // (counter value MEM_TIMEOUT-1 before its increment). RUN never times out:
  // its first stall cycle just enters MEM_WAIT with a fresh counter.
  assign timeout   = (state_q != ST_RUN) && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
  assign mem_stall = mem_access && !i_dmem_ready && !timeout;

  // Branch / load-use priority used whenever no memory stall is active.
  always_comb begin
    ctrl_evt = CTRL_RUN;
    if (i_EX_BranchTaken) begin
      ctrl_evt.if_id_flush  = 1'b1;
      ctrl_evt.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      ctrl_evt.pc_write     = 1'b0;
      ctrl_evt.if_id_write  = 1'b0;
      ctrl_evt.id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    dr_cnt_d = dr_cnt_q;
    ctrl     = CTRL_RUN;
    dmem_req = 1'b0;
    mem_err  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      ST_RUN: begin
        dmem_req = mem_access;
        if (mem_stall) begin
          ctrl    = CTRL_MEM_STALL;
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl = ctrl_evt;
          if (i_halt_req) state_d = ST_DRAIN;
        end
      end

      ST_MEM_WAIT: begin
        dmem_req = mem_access;
        if (mem_stall) begin
          ctrl     = CTRL_MEM_STALL;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
          // Release cycle: a branch held at the EX input is acted on now
          ctrl    = ctrl_evt;
          mem_err = mem_access && !i_dmem_ready;
          state_d = i_halt_req ? ST_DRAIN : ST_RUN;
        end
      end

      ST_DRAIN: begin
        dmem_req = mem_access;
        if (mem_stall) begin
          // Drain count pauses while memory holds the back end
          ctrl     = CTRL_MEM_STALL;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else if (load_use && !i_EX_BranchTaken) begin
          // Keep the dependent ID instruction alive; drain count pauses
          ctrl     = ctrl_evt;
          mem_err  = mem_access && !i_dmem_ready;
          to_cnt_d = '0;
        end else begin
          ctrl              = CTRL_RUN;
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = i_EX_BranchTaken;
          mem_err           = mem_access && !i_dmem_ready;
          to_cnt_d          = '0;
          if (dr_cnt_q == DR_W'(DRAIN_CYCLES - 1)) begin
            state_d = ST_HALTED;
          end else begin
            dr_cnt_d = dr_cnt_q + DR_W'(1);
          end
        end
      end

      default: begin // ST_HALTED
        ctrl   = CTRL_STALLED;
        halted = 1'b1;
        if (!i_halt_req) state_d = ST_RUN;
      end
    endcase

    // Both counters restart on every state change
    if (state_d != state_q) begin
      to_cnt_d = '0;
      dr_cnt_d = '0;
    end

    if (rst) begin
      ctrl     = CTRL_STALLED;
      dmem_req = 1'b0;
      mem_err  = 1'b0;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      to_cnt_q <= '0;
      dr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      dr_cnt_q <= dr_cnt_d;
    end
  end

  assign o_PCWrite       = ctrl.pc_write;
  assign o_IF_ID_Write   = ctrl.if_id_write;
  assign o_IF_ID_Flush   = ctrl.if_id_flush;
  assign o_ID_EX_Bubble  = ctrl.id_ex_bubble;
  assign o_EX_MEM_Hold   = ctrl.ex_mem_hold;
  assign o_MEM_WB_Bubble = ctrl.mem_wb_bubble;
  assign o_dmem_req      = dmem_req;
  assign o_mem_err       = mem_err;
  assign o_halted        = halted;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_write && (state_q != ST_HALTED) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cycles = stall_cnt_q;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  i_ID_rs, i_ID_rt, i_EX_WriteReg;
  logic        i_ID_UsesRs, i_ID_UsesRt, i_EX_MemRead, i_EX_BranchTaken;
  logic        i_MEM_MemRead, i_MEM_MemWrite, i_dmem_ready, i_halt_req;
  logic        o_PCWrite, o_IF_ID_Write, o_IF_ID_Flush, o_ID_EX_Bubble;
  logic        o_EX_MEM_Hold, o_MEM_WB_Bubble, o_dmem_req, o_mem_err, o_halted;
  logic [31:0] o_stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_ID_rs(i_ID_rs), .i_ID_rt(i_ID_rt),
    .i_ID_UsesRs(i_ID_UsesRs), .i_ID_UsesRt(i_ID_UsesRt),
    .i_EX_MemRead(i_EX_MemRead), .i_EX_WriteReg(i_EX_WriteReg),
    .i_EX_BranchTaken(i_EX_BranchTaken),
    .i_MEM_MemRead(i_MEM_MemRead), .i_MEM_MemWrite(i_MEM_MemWrite),
    .i_dmem_ready(i_dmem_ready), .i_halt_req(i_halt_req),
    .o_PCWrite(o_PCWrite), .o_IF_ID_Write(o_IF_ID_Write), .o_IF_ID_Flush(o_IF_ID_Flush),
    .o_ID_EX_Bubble(o_ID_EX_Bubble), .o_EX_MEM_Hold(o_EX_MEM_Hold),
    .o_MEM_WB_Bubble(o_MEM_WB_Bubble), .o_dmem_req(o_dmem_req),
    .o_mem_err(o_mem_err), .o_halted(o_halted), .o_stall_cycles(o_stall_cycles)
  );

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold, MEM_WB_Bubble}
  function automatic logic [5:0] ctl();
    return {o_PCWrite, o_IF_ID_Write, o_IF_ID_Flush, o_ID_EX_Bubble, o_EX_MEM_Hold, o_MEM_WB_Bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_ID_rs = 5'd0; i_ID_rt = 5'd0; i_ID_UsesRs = 1'b0; i_ID_UsesRt = 1'b0;
    i_EX_MemRead = 1'b0; i_EX_WriteReg = 5'd0; i_EX_BranchTaken = 1'b0;
    i_MEM_MemRead = 1'b0; i_MEM_MemWrite = 1'b0; i_dmem_ready = 1'b1; i_halt_req = 1'b0;
  endtask

  // Leaves the bench just after a negedge with reset released and state RUN
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, ld;
    logic [4:0] wr;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b111100;
  localparam logic [5:0] C_MEM   = 6'b000011;
  localparam logic [5:0] C_DRAIN = 6'b011000;
  localparam logic [5:0] C_STALL = 6'b000101;

  vec_t tv [10];
  int   exp_stall;

  initial begin
    //         rs     rt    urs   urt   ld    wr    br    expected
    tv[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, C_RUN}; // idle
    tv[1] = '{5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, C_LU};  // load r5, rt=5
    tv[2] = '{5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, C_RUN}; // r0 never hazards
    tv[3] = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, C_LU};  // rs match
    tv[4] = '{5'd7, 5'd2, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, C_RUN}; // rs match, not used
    tv[5] = '{5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, C_RUN}; // EX not a load
    tv[6] = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, C_RUN}; // no register match
    tv[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, C_BR};  // taken branch
    tv[8] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, C_BR};  // branch beats load-use
    tv[9] = '{5'd31,5'd31,1'b0, 1'b1, 1'b1, 5'd31,1'b0, C_LU};  // r31 rt match

    // Reset state: stalled controls, no request, flags low
    rst = 1'b1;
    clear_inputs();
    i_MEM_MemRead = 1'b1;
    @(negedge clk); #1;
    chk("rst_ctl", 32'(ctl()), 32'(C_STALL));
    chk("rst_flags", {29'd0, o_dmem_req, o_mem_err, o_halted}, 32'd0);
    chk("rst_stall_cnt", o_stall_cycles, 32'd0);

    // Table: single-cycle decoding in RUN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_ID_rs = tv[i].rs; i_ID_rt = tv[i].rt;
      i_ID_UsesRs = tv[i].urs; i_ID_UsesRt = tv[i].urt;
      i_EX_MemRead = tv[i].ld; i_EX_WriteReg = tv[i].wr; i_EX_BranchTaken = tv[i].br;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(tv[i].exp));
      @(negedge clk);
    end

    // Memory wait of 3 cycles, then ready
    do_reset();
    i_MEM_MemRead = 1'b1; i_dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("memwait_c%0d", c), 32'(ctl()), 32'(C_MEM));
      chk($sformatf("memwait_req%0d", c), 32'(o_dmem_req), 32'd1);
      @(negedge clk);
    end
    i_dmem_ready = 1'b1;
    #1;
    chk("memwait_release", 32'(ctl()), 32'(C_RUN));
    @(negedge clk);
    i_MEM_MemRead = 1'b0;
    #1;
    chk("memwait_after", 32'(ctl()), 32'(C_RUN));
`ifdef PIPE_PERF_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    chk("memwait_stall_cnt", o_stall_cycles, 32'(exp_stall));

    // Ready never arrives: err on the 4th MEM_WAIT cycle, then back to RUN
    do_reset();
    i_MEM_MemWrite = 1'b1; i_dmem_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("timeout_err_c%0d", c), 32'(o_mem_err), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("timeout_ctl_c%0d", c), 32'(ctl()), (c == 4) ? 32'(C_RUN) : 32'(C_MEM));
      @(negedge clk);
    end
    i_MEM_MemWrite = 1'b0;
    #1;
    chk("timeout_after", 32'(ctl()), 32'(C_RUN));

    // Branch pending during a memory wait fires only in the release cycle
    do_reset();
    i_MEM_MemRead = 1'b1; i_dmem_ready = 1'b0; i_EX_BranchTaken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("brwait_c%0d", c), 32'(ctl()), 32'(C_MEM));
      @(negedge clk);
    end
    i_dmem_ready = 1'b1;
    #1;
    chk("brwait_release", 32'(ctl()), 32'(C_BR));
    @(negedge clk);
    i_EX_BranchTaken = 1'b0; i_MEM_MemRead = 1'b0;
    #1;
    chk("brwait_after", 32'(ctl()), 32'(C_RUN));

    // Halt: 4 drain cycles, then halted; dropping the request returns to RUN
    do_reset();
    i_halt_req = 1'b1;
    #1;
    chk("halt_run_cycle", {26'd0, ctl()}, 32'(C_RUN));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("drain_c%0d", c), {25'd0, o_halted, ctl()}, {25'd0, 1'b0, C_DRAIN});
    end
    @(negedge clk); #1;
    chk("halted_ctl", {25'd0, o_halted, o_dmem_req, ctl()}, {25'd0, 1'b1, 1'b0, C_STALL});
    i_halt_req = 1'b0;
    #1;
    chk("halted_hold", 32'(o_halted), 32'd1);
    @(negedge clk); #1;
    chk("unhalt", {25'd0, o_halted, ctl()}, {25'd0, 1'b0, C_RUN});

    // Reset in the middle of DRAIN
    i_halt_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_drain_forced", {25'd0, o_halted, ctl()}, {25'd0, 1'b0, C_STALL});
    @(negedge clk);
    rst = 1'b0;   // request still high: RUN shows normal enables, DRAIN would not
    #1;
    chk("rst_drain_run", {25'd0, o_halted, ctl()}, {25'd0, 1'b0, C_RUN});
    i_halt_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
